// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared state encoding and default sizes for the word memory bank
package memory_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/word_memory_bank_if.sv
// rtl/word_memory_bank_if.sv - write/read/clear bus between the datapath and the word memory bank
interface word_memory_bank_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]  data;
   logic              store;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] rd_addr;
   logic              clear;
   logic [WIDTH-1:0]  memory;
   logic              busy;
   logic              clear_done;

   modport master (
      output data, store, addr, rd_addr, clear,
      input  memory, busy, clear_done
   );

   modport slave (
      input  data, store, addr, rd_addr, clear,
      output memory, busy, clear_done
   );
endinterface

// File: rtl/word_cell.sv
// rtl/word_cell.sv - one stored word: async reset, load enable, synchronous zero
module word_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             zero,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // zero has priority so a sweep always wins over any stray load
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else if (zero)
         q <= '0;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/word_memory_bank.sv
// rtl/word_memory_bank.sv - DEPTH x WIDTH register bank with registered read and a one-entry-per-cycle clear sweep
module word_memory_bank
   import memory_pkg::*;
#(
   parameter  int WIDTH  = DEFAULT_WIDTH,
   parameter  int DEPTH  = DEFAULT_DEPTH,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   word_memory_bank_if.slave  bus
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] idx;
   logic [WIDTH-1:0]  cell_q [DEPTH];
   logic [WIDTH-1:0]  rd_word;
   logic [WIDTH-1:0]  memory_q;
   logic              clear_done_q;
   logic              write_en;

   // clear in the same cycle as store takes precedence and drops the write
   assign write_en = (state == IDLE) && bus.store && !bus.clear;

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      word_cell #(.WIDTH(WIDTH)) u_cell (
         .clk   (clk),
         .reset (reset),
         .load  (write_en && (bus.addr == ADDR_W'(i))),
         .zero  ((state == CLEAR) && (idx == ADDR_W'(i))),
         .d     (bus.data),
         .q     (cell_q[i])
      );
   end

   // addresses with no matching entry fall through to zero
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.rd_addr == ADDR_W'(i))
            rd_word = cell_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         memory_q     <= '0;
         clear_done_q <= 1'b0;
      end else begin
         memory_q     <= rd_word;
         clear_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.clear) begin
                  state <= CLEAR;
                  idx   <= '0;
               end
            end
            CLEAR: begin
               if (idx == LAST_IDX) begin
                  state        <= IDLE;
                  idx          <= '0;
                  clear_done_q <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   assign bus.memory     = memory_q;
   assign bus.busy       = (state == CLEAR);
   assign bus.clear_done = clear_done_q;

endmodule

// File: tb/tb_word_memory_bank.sv
// tb/tb_word_memory_bank.sv - directed self-checking bench for word_memory_bank (8x4 and 16x8 instances)
module tb_word_memory_bank;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   int   wait_cnt;

   always #5 clk = ~clk;

   word_memory_bank_if #(.WIDTH(8),  .DEPTH(4)) ia ();
   word_memory_bank_if #(.WIDTH(16), .DEPTH(8)) ib ();

   word_memory_bank #(.WIDTH(8),  .DEPTH(4)) dut_a (.clk(clk), .reset(reset), .bus(ia));
   word_memory_bank #(.WIDTH(16), .DEPTH(8)) dut_b (.clk(clk), .reset(reset), .bus(ib));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [1:0] a, input logic [7:0] d);
      ia.store = 1'b1;
      ia.addr  = a;
      ia.data  = d;
      tick();
      ia.store = 1'b0;
   endtask

   task automatic rd_a(input string tag, input logic [1:0] a, input logic [7:0] exp);
      ia.rd_addr = a;
      tick();
      check_val(tag, {24'h0, ia.memory}, {24'h0, exp});
   endtask

   task automatic wait_idle_a(input string tag);
      wait_cnt = 0;
      while (ia.busy && wait_cnt < 20) begin
         tick();
         wait_cnt++;
      end
      check_val(tag, {31'h0, ia.busy}, 32'h0);
   endtask

   initial begin
      reset = 1'b1;
      ia.data = '0; ia.store = 1'b0; ia.addr = '0; ia.rd_addr = '0; ia.clear = 1'b0;
      ib.data = '0; ib.store = 1'b0; ib.addr = '0; ib.rd_addr = '0; ib.clear = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      check_val("rst_busy", {31'h0, ia.busy}, 32'h0);
      check_val("rst_done", {31'h0, ia.clear_done}, 32'h0);
      for (int i = 0; i < 4; i++) rd_a($sformatf("rst_rd%0d", i), 2'(i), 8'h00);

      // basic write/read
      wr_a(2'd0, 8'hA5);
      wr_a(2'd3, 8'h3C);
      rd_a("rd0", 2'd0, 8'hA5);
      rd_a("rd1", 2'd1, 8'h00);
      rd_a("rd3", 2'd3, 8'h3C);

      // same-cycle read and write returns old contents
      wr_a(2'd2, 8'h11);
      ia.store = 1'b1; ia.addr = 2'd2; ia.data = 8'h77; ia.rd_addr = 2'd2;
      tick();
      ia.store = 1'b0;
      check_val("rw_old", {24'h0, ia.memory}, 32'h11);
      tick();
      check_val("rw_new", {24'h0, ia.memory}, 32'h77);

      // full clear sweep, with an ignored store and an ignored clear while busy
      for (int i = 0; i < 4; i++) wr_a(2'(i), 8'hFF);
      ia.clear = 1'b1;
      tick();
      ia.clear = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_val($sformatf("sw_busy%0d", k), {31'h0, ia.busy}, 32'h1);
         check_val($sformatf("sw_done%0d", k), {31'h0, ia.clear_done}, 32'h0);
         if (k == 1) ia.clear = 1'b1;
         if (k == 2) begin
            ia.store = 1'b1; ia.addr = 2'd1; ia.data = 8'h55;
         end
         tick();
         ia.clear = 1'b0;
         ia.store = 1'b0;
      end
      check_val("sw_end_busy", {31'h0, ia.busy}, 32'h0);
      check_val("sw_end_done", {31'h0, ia.clear_done}, 32'h1);
      tick();
      check_val("sw_done_once", {31'h0, ia.clear_done}, 32'h0);
      for (int i = 0; i < 4; i++) rd_a($sformatf("sw_rd%0d", i), 2'(i), 8'h00);

      // clear and store in the same cycle
      ia.clear = 1'b1; ia.store = 1'b1; ia.addr = 2'd0; ia.data = 8'h99;
      tick();
      ia.clear = 1'b0; ia.store = 1'b0;
      check_val("cs_busy", {31'h0, ia.busy}, 32'h1);
      wait_idle_a("cs_idle");
      rd_a("cs_rd0", 2'd0, 8'h00);

      // reset in the second sweep cycle aborts without clear_done
      wr_a(2'd2, 8'hEE);
      wr_a(2'd3, 8'hEE);
      ia.clear = 1'b1;
      tick();
      ia.clear = 1'b0;
      tick();
      check_val("ab_busy_pre", {31'h0, ia.busy}, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check_val("ab_busy_rst", {31'h0, ia.busy}, 32'h0);
      check_val("ab_done_rst", {31'h0, ia.clear_done}, 32'h0);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         ia.rd_addr = 2'(k);
         tick();
         check_val($sformatf("ab_done%0d", k), {31'h0, ia.clear_done}, 32'h0);
         check_val($sformatf("ab_rd%0d", k), {24'h0, ia.memory}, 32'h0);
      end

      // 16-bit x 8 instance: write/read and same-cycle behaviour
      ib.store = 1'b1; ib.addr = 3'd7; ib.data = 16'hBEEF;
      tick();
      ib.addr = 3'd5; ib.data = 16'h1234;
      tick();
      ib.store = 1'b0;
      ib.rd_addr = 3'd7; tick(); check_val("b_rd7", {16'h0, ib.memory}, 32'hBEEF);
      ib.rd_addr = 3'd5; tick(); check_val("b_rd5", {16'h0, ib.memory}, 32'h1234);
      ib.rd_addr = 3'd6; tick(); check_val("b_rd6", {16'h0, ib.memory}, 32'h0000);
      ib.store = 1'b1; ib.addr = 3'd5; ib.data = 16'hCAFE; ib.rd_addr = 3'd5;
      tick();
      ib.store = 1'b0;
      check_val("b_rw_old", {16'h0, ib.memory}, 32'h1234);
      tick();
      check_val("b_rw_new", {16'h0, ib.memory}, 32'hCAFE);

      // 16-bit x 8 sweep length
      ib.clear = 1'b1;
      tick();
      ib.clear = 1'b0;
      wait_cnt = 0;
      while (ib.busy && wait_cnt < 30) begin
         tick();
         wait_cnt++;
      end
      check_val("b_sweep_len", wait_cnt, 32'd8);
      check_val("b_sweep_done", {31'h0, ib.clear_done}, 32'h1);
      ib.rd_addr = 3'd7; tick(); check_val("b_clr_rd7", {16'h0, ib.memory}, 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/word_memory_bank.md
Name: word_memory_bank

Overview:
- Parametrised, clocked successor to the 4-entry byte store. It holds DEPTH words of WIDTH bits with independent write and read addresses and a registered read port.
- A hardware clear sequencer zeroes every entry on request, one entry per cycle.
- It sits between the datapath and the display/readback logic as the team's general-purpose small register bank.

Parameters:
- WIDTH, 8, bits per stored word.
- DEPTH, 4, number of entries; must be >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data  input  WIDTH  write data.
- store  input  1  write enable; samples data into entry addr.
- addr  input  ADDR_W  write address.
- rd_addr  input  ADDR_W  read address.
- clear  input  1  single-cycle request to zero all entries.
- memory  output  WIDTH  registered read data.
- busy  output  1  high while the clear sweep runs.
- clear_done  output  1  one-cycle pulse after the last entry is cleared.

Behaviour:
- Reset (async, active-high):
  - All entries go to 0.
  - memory=0, busy=0, clear_done=0, FSM=IDLE, sweep index=0.
  - Reset asserted mid-sweep aborts the sweep immediately; no clear_done pulse is produced.
- Write:
  - In IDLE with store=1, entry[addr] <= data at the clock edge.
  - Only one entry changes per write; all others hold.
  - Addresses >= DEPTH (non-power-of-2 DEPTH) are ignored: no write.
- Read:
  - memory <= entry[rd_addr] every cycle. Latency is one cycle, always enabled.
  - rd_addr >= DEPTH returns 0.
  - Read and write to the same address in the same cycle return the OLD contents; the new value appears on the next read.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear=1. The index loads 0 and busy goes high on the next cycle.
  - In CLEAR, each cycle: entry[index] <= 0, then index += 1.
  - When index == DEPTH-1 the entry is cleared, the FSM returns to IDLE, and clear_done pulses high for exactly one cycle (the cycle busy returns low).
  - The sweep takes exactly DEPTH cycles with busy=1.
- Simultaneous events:
  - store and clear in the same IDLE cycle: clear wins, and the write is dropped.
  - store while busy is ignored, with no queuing.
  - clear while busy is ignored; the sweep does not restart.
- Reads during CLEAR return current contents, so already-swept entries read as 0 and the rest hold old values.
- Index arithmetic is ADDR_W bits with no wrap beyond DEPTH-1; the terminal compare is DEPTH-1.

Decomposition:
- Shared package (memory_pkg):
  - State enum {IDLE, CLEAR}.
  - Default WIDTH/DEPTH constants.
- One natural sub-module: word_cell, parametrised by WIDTH. It is a single register with async reset, a load enable and a synchronous zero input; DEPTH copies are generated.
- Address decode, read mux and FSM stay in the top module.

Test Plan:
- Reset then read all addresses -> memory=0 for every rd_addr; busy=0, clear_done=0.
- Write 8'hA5 @0, 8'h3C @3, then read 0,1,3 -> memory shows A5, 00, 3C, each one cycle after rd_addr is applied.
- Same-cycle store 8'h77 @2 and rd_addr=2 with old value 8'h11 -> next cycle memory=11; following cycle 77.
- Fill all 4 entries with 8'hFF, pulse clear -> busy high for 4 cycles, clear_done pulses once when busy falls, all entries read 0. A store of 8'h55 @1 during busy is ignored (entry 1 reads 0).
- clear and store 8'h99 @0 in the same cycle -> entry 0 reads 0 after the sweep.
- Assert reset in the 2nd sweep cycle with entries 2,3 = 8'hEE -> all entries 0, busy=0 immediately, no clear_done pulse; repeat the write/read checks with WIDTH=16, DEPTH=8.
